// File: rtl/rv_wb_pkg.sv
// rtl/rv_wb_pkg.sv - shared types and constants for the RV32I writeback stage
//
// Purpose: result-select encoding, load funct3 codes and default widths.
// Ports: none (package).
package rv_wb_pkg;

  localparam int DATAWIDTH_DEF = 32;
  localparam int WIDTH_DEF     = 5;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_BAD  = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// rtl/writeback_stage_load_extend.sv - load byte/halfword extraction and extension
//
// Purpose: pick the addressed byte/halfword out of an aligned word and
//          sign- or zero-extend it; flag funct3 codes that are not loads.
// Ports:
//   word       in   raw aligned 32-bit memory word
//   offset     in   byte offset within the word (address[1:0])
//   load_type  in   load funct3
//   data       out  extended load value
//   illegal    out  funct3 is not a legal load encoding
module load_extend
  import rv_wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] data,
  output logic        illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[8*offset +: 8];
    // Halfword selection ignores offset[0]; misalignment is not trapped here.
    w_half = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data    = '0;
    illegal = 1'b0;
    case (load_type)
      F3_LB:   data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   data = {{16{w_half[15]}}, w_half};
      F3_LW:   data = word;
      F3_LBU:  data = {24'b0, w_byte};
      F3_LHU:  data = {16'b0, w_half};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB pipeline register and register-file writeback
//
// Purpose: capture the retiring instruction from MEM, build the final result
//          and drive the register file write port; export forwarding view,
//          retired-instruction count and sticky decode error.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   stall_w, flush_w                hold / bubble the MEM/WB register
//   valid_m .. pc_plus4_m           MEM-stage instruction fields
//   AD3, WE3, WD3                   register file write port
//   rd_w, reg_write_w, result_w     hazard/forwarding view of WB
//   instret                         retired-instruction counter
//   err                             sticky illegal-instruction flag
module writeback_stage
  import rv_wb_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int WIDTH     = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_w,
  input  logic                 flush_w,
  input  logic                 valid_m,
  input  logic                 reg_write_m,
  input  logic [1:0]           result_src_m,
  input  logic [2:0]           load_type_m,
  input  logic [WIDTH-1:0]     rd_m,
  input  logic [DATAWIDTH-1:0] alu_result_m,
  input  logic [DATAWIDTH-1:0] read_data_m,
  input  logic [DATAWIDTH-1:0] pc_plus4_m,
  output logic [WIDTH-1:0]     AD3,
  output logic                 WE3,
  output logic [DATAWIDTH-1:0] WD3,
  output logic [WIDTH-1:0]     rd_w,
  output logic                 reg_write_w,
  output logic [DATAWIDTH-1:0] result_w,
  output logic [31:0]          instret,
  output logic                 err
);

  logic                 r_valid;
  logic                 r_reg_write;
  result_src_e          r_result_src;
  logic [2:0]           r_load_type;
  logic [WIDTH-1:0]     r_rd;
  logic [DATAWIDTH-1:0] r_alu_result;
  logic [DATAWIDTH-1:0] r_read_data;
  logic [DATAWIDTH-1:0] r_pc_plus4;
  logic [31:0]          r_instret;
  logic                 r_err;

  logic [31:0]          w_load_data;
  logic                 w_load_illegal;
  logic                 w_illegal;
  logic                 w_retire;
  logic [DATAWIDTH-1:0] w_result;
  logic                 w_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_result_src <= RES_ALU;
      r_load_type  <= '0;
      r_rd         <= '0;
      r_alu_result <= '0;
      r_read_data  <= '0;
      r_pc_plus4   <= '0;
    end else if (flush_w) begin
      // Bubble: only valid matters; the rest is left as-is.
      r_valid <= 1'b0;
    end else if (!stall_w) begin
      r_valid      <= valid_m;
      r_reg_write  <= reg_write_m;
      r_result_src <= result_src_e'(result_src_m);
      r_load_type  <= load_type_m;
      r_rd         <= rd_m;
      r_alu_result <= alu_result_m;
      r_read_data  <= read_data_m;
      r_pc_plus4   <= pc_plus4_m;
    end
  end

  load_extend u_load_extend (
    .word      (r_read_data[31:0]),
    .offset    (r_alu_result[1:0]),
    .load_type (r_load_type),
    .data      (w_load_data),
    .illegal   (w_load_illegal)
  );

  always_comb begin
    w_result = '0;
    case (r_result_src)
      RES_ALU:  w_result = r_alu_result;
      RES_LOAD: w_result = DATAWIDTH'(w_load_data);
      RES_PC4:  w_result = r_pc_plus4;
      default:  w_result = '0;
    endcase
  end

  assign w_illegal = (r_result_src == RES_BAD) |
                     ((r_result_src == RES_LOAD) & w_load_illegal);
  assign w_we      = r_valid & r_reg_write & (r_rd != '0) & ~w_illegal;
  // The W instruction leaves the stage whenever the register advances,
  // including when a flush replaces it with a bubble.
  assign w_retire  = r_valid & (~stall_w | flush_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
      r_err     <= 1'b0;
    end else if (w_retire) begin
      r_instret <= r_instret + 32'd1;
      if (w_illegal) r_err <= 1'b1;
    end
  end

  assign AD3         = r_rd;
  assign WE3         = w_we;
  assign WD3         = w_result;
  assign rd_w        = r_rd;
  assign reg_write_w = w_we;
  assign result_w    = w_result;
  assign instret     = r_instret;
  assign err         = r_err;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_w, flush_w, valid_m, reg_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  load_type_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m, read_data_m, pc_plus4_m;
  logic [4:0]  AD3, rd_w;
  logic        WE3, reg_write_w, err;
  logic [31:0] WD3, result_w, instret;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_w      (stall_w),
    .flush_w      (flush_w),
    .valid_m      (valid_m),
    .reg_write_m  (reg_write_m),
    .result_src_m (result_src_m),
    .load_type_m  (load_type_m),
    .rd_m         (rd_m),
    .alu_result_m (alu_result_m),
    .read_data_m  (read_data_m),
    .pc_plus4_m   (pc_plus4_m),
    .AD3          (AD3),
    .WE3          (WE3),
    .WD3          (WD3),
    .rd_w         (rd_w),
    .reg_write_w  (reg_write_w),
    .result_w     (result_w),
    .instret      (instret),
    .err          (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                       input logic [2:0] lt, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4);
    valid_m = v; reg_write_m = rw; result_src_m = src; load_type_m = lt;
    rd_m = rd; alu_result_m = alu; read_data_m = rdata; pc_plus4_m = pc4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic we, input logic [4:0] ad,
                        input logic [31:0] wd, input logic [31:0] ir);
    chk({tag, "_we"}, {31'b0, WE3}, {31'b0, we});
    chk({tag, "_ad3"}, {27'b0, AD3}, {27'b0, ad});
    chk({tag, "_wd3"}, WD3, wd);
    chk({tag, "_fwd"}, result_w, wd);
    chk({tag, "_rw"}, {31'b0, reg_write_w}, {31'b0, we});
    chk({tag, "_instret"}, instret, ir);
  endtask

  localparam logic [31:0] MEMW = 32'h80FF7F01;

  initial begin
    rst_n = 1'b0; stall_w = 1'b0; flush_w = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    #2;
    chk_wb("reset", 1'b0, 5'd0, 32'h0, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU write to x0: suppressed but still counted on retire
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd0, 32'h1234, 32'h0, 32'h0);
    tick();
    chk_wb("x0", 1'b0, 5'd0, 32'h1234, 32'h0);

    // Loads from 0x80FF7F01 into x5
    drive(1'b1, 1'b1, 2'b01, 3'b000, 5'd5, 32'h1001, MEMW, 32'h0);
    tick(); chk_wb("lb_off1", 1'b1, 5'd5, 32'h0000007F, 32'd1);
    drive(1'b1, 1'b1, 2'b01, 3'b000, 5'd5, 32'h1003, MEMW, 32'h0);
    tick(); chk_wb("lb_off3", 1'b1, 5'd5, 32'hFFFFFF80, 32'd2);
    drive(1'b1, 1'b1, 2'b01, 3'b100, 5'd5, 32'h1002, MEMW, 32'h0);
    tick(); chk_wb("lbu_off2", 1'b1, 5'd5, 32'h000000FF, 32'd3);
    drive(1'b1, 1'b1, 2'b01, 3'b001, 5'd5, 32'h1002, MEMW, 32'h0);
    tick(); chk_wb("lh_off2", 1'b1, 5'd5, 32'hFFFF80FF, 32'd4);
    drive(1'b1, 1'b1, 2'b01, 3'b101, 5'd5, 32'h1000, MEMW, 32'h0);
    tick(); chk_wb("lhu_off0", 1'b1, 5'd5, 32'h00007F01, 32'd5);
    drive(1'b1, 1'b1, 2'b01, 3'b010, 5'd5, 32'h1002, MEMW, 32'h0);
    tick(); chk_wb("lw_off2", 1'b1, 5'd5, MEMW, 32'd6);

    // JAL return address
    drive(1'b1, 1'b1, 2'b10, 3'b000, 5'd1, 32'hDEAD0000, 32'h0, 32'h00000104);
    tick(); chk_wb("jal", 1'b1, 5'd1, 32'h00000104, 32'd7);

    // Stall three cycles: JAL held, rewritten, not counted
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd2, 32'h0000AAAA, 32'h0, 32'h0);
    stall_w = 1'b1;
    tick(); chk_wb("stall1", 1'b1, 5'd1, 32'h00000104, 32'd7);
    tick(); chk_wb("stall2", 1'b1, 5'd1, 32'h00000104, 32'd7);
    tick(); chk_wb("stall3", 1'b1, 5'd1, 32'h00000104, 32'd7);
    stall_w = 1'b0;
    tick(); chk_wb("unstall", 1'b1, 5'd2, 32'h0000AAAA, 32'd8);

    // Flush with stall: bubble, current W retires
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 32'h00000055, 32'h0, 32'h0);
    stall_w = 1'b1; flush_w = 1'b1;
    tick();
    chk("flush_we", {31'b0, WE3}, 32'h0);
    chk("flush_instret", instret, 32'd9);
    stall_w = 1'b0; flush_w = 1'b0;

    // Illegal result_src
    drive(1'b1, 1'b1, 2'b11, 3'b000, 5'd4, 32'h77, 32'h0, 32'h0);
    tick();
    chk("bad_we", {31'b0, WE3}, 32'h0);
    chk("bad_wd3", WD3, 32'h0);
    chk("bad_err_pre", {31'b0, err}, 32'h0);
    chk("bad_instret", instret, 32'd9);
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("bad_err_set", {31'b0, err}, 32'h1);
    chk("bad_instret2", instret, 32'd10);
    tick();
    chk("bad_err_sticky", {31'b0, err}, 32'h1);

    // Illegal load funct3
    drive(1'b1, 1'b1, 2'b01, 3'b011, 5'd6, 32'h0, MEMW, 32'h0);
    tick();
    chk("badld_we", {31'b0, WE3}, 32'h0);
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("badld_instret", instret, 32'd11);
    chk("badld_err", {31'b0, err}, 32'h1);

    // Counter wrap from a preloaded value
    @(negedge clk);
    force dut.r_instret = 32'hFFFFFFFF;
    #1;
    release dut.r_instret;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd7, 32'h1, 32'h0, 32'h0);
    tick();
    chk("wrap_pre", instret, 32'hFFFFFFFF);
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("wrap_post", instret, 32'h0);

    // Reset during a stall discards the held instruction
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd8, 32'h99, 32'h0, 32'h0);
    tick();
    stall_w = 1'b1;
    tick();
    chk_wb("prerst", 1'b1, 5'd8, 32'h99, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_wb("midrst", 1'b0, 5'd0, 32'h0, 32'h0);
    chk("midrst_err", {31'b0, err}, 32'h0);
    chk("midrst_rdw", {27'b0, rd_w}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; stall_w = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    chk_wb("postrst", 1'b0, 5'd0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

MEM/WB pipeline register plus writeback logic for the RV32I core. It captures a retiring instruction's results from the memory stage and performs load byte/halfword extraction and sign/zero extension. It selects the final result and drives the register file write port (AD3/WE3/WD3) one cycle later. It also exports writeback-stage forwarding/hazard signals, a retired-instruction counter and a sticky decode-error flag.

## Interface
- DATAWIDTH, 32, datapath width
- WIDTH, 5, register address width
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- stall_w  input  1  hold MEM/WB register contents
- flush_w  input  1  load a bubble into MEM/WB register (priority over stall_w)
- valid_m  input  1  MEM stage holds a real instruction
- reg_write_m  input  1  instruction writes rd
- result_src_m  input  2  00 ALU, 01 load, 10 PC+4, 11 illegal
- load_type_m  input  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
- rd_m  input  WIDTH  destination register
- alu_result_m  input  DATAWIDTH  ALU result / load address
- read_data_m  input  DATAWIDTH  raw aligned 32-bit word from data memory
- pc_plus4_m  input  DATAWIDTH  return address for JAL/JALR
- AD3  output  WIDTH  register file write address
- WE3  output  1  register file write enable
- WD3  output  DATAWIDTH  register file write data
- rd_w, reg_write_w  output  WIDTH, 1  hazard unit view of the WB instruction (reg_write_w = WE3)
- result_w  output  DATAWIDTH  forwarding value (= WD3)
- instret  output  32  retired-instruction count
- err  output  1  sticky: illegal result_src or load_type retired

## Operation
- MEM/WB register fields are valid_w, reg_write_w_q, result_src_w, load_type_w, rd_w, alu_result_w, read_data_w, pc_plus4_w.
- Edge update priority: flush_w → valid_w=0, other fields don't-care; else stall_w → hold; else load all *_m inputs.
- Load extraction uses byte offset alu_result_w[1:0]:
  - LB/LBU: byte at offset, sign-/zero-extended.
  - LH/LHU: halfword at offset[1] (offset[0] ignored), sign-/zero-extended.
  - LW: full word; offset ignored.
- Result select: 00 alu_result_w, 01 extended load, 10 pc_plus4_w, 11 → 0.
- Write enable: WE3 = valid_w & reg_write_w_q & (rd_w != 0) & ~illegal.
  - illegal = (result_src_w==11) | (result_src_w==01 & load_type_w ∉ legal set).
  - Writes to x0 are always suppressed.
- AD3 = rd_w, WD3 = selected result; combinational from the register.
- Retire event: valid_w=1 at an edge where the register advances (stall_w=0 or flush_w=1).
  - instret increments by 1 per retire event, wrapping 0xFFFFFFFF→0.
- err sets on a retire event with illegal=1 and clears only on reset.

## Timing
- Reset (asynchronous, immediate): valid_w=0 and all fields 0, so WE3=0, AD3=0, WD3=0, rd_w=0, reg_write_w=0, result_w=0, instret=0, err=0.
- Latency: *_m sampled at edge N; WE3/WD3 valid after edge N; register file written at edge N+1.
- Under stall_w, WE3 stays asserted and the same value is rewritten each cycle (idempotent); instret does not count.
- flush_w together with stall_w acts as flush; the current W instruction retires and counts.
- Reset asserted mid-stall or mid-operation discards the held instruction with no write and no count.
- A load targeting x0 retires and counts with WE3=0.

## Structure
- Package rv_wb_pkg holds:
  - result_src enum (RES_ALU, RES_LOAD, RES_PC4, RES_BAD)
  - funct3 load constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU)
  - the shared DATAWIDTH/WIDTH defaults
- Sub-module load_extend is purely combinational.
  - Inputs: word, offset[1:0], load_type.
  - Outputs: extended data, illegal flag.
- The top module holds the pipeline register, counter and err.

## Test plan
- Reset/x0:
  - Assert rst_n=0 mid-stream → all outputs 0 immediately.
  - Issue ALU write rd=0, value 0x1234 → WE3=0; instret increments.
- Loads: read_data_m=0x80FF7F01, rd=5.
  - LB off 1 → 0x0000007F; LB off 3 → 0xFFFFFF80; LBU off 2 → 0x000000FF.
  - LH off 2 → 0xFFFF80FF; LHU off 0 → 0x00007F01.
- Select: JAL with pc_plus4_m=0x00000104, rd=1 → next cycle AD3=1, WE3=1, WD3=0x00000104.
- Stall/flush:
  - Hold stall_w 3 cycles → WE3/WD3 stable; instret +1 total once released.
  - flush_w+stall_w together → bubble next cycle (WE3=0).
- Errors/wrap:
  - result_src_m=11 → WE3=0, err=1 after retire, stays 1 until reset.
  - Force instret to 0xFFFFFFFF by retiring 2^32−1 instructions (or a preloaded counter in the bench) → next retire gives 0.
